// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard control unit for a 5-stage pipeline. It takes the decoded
//   register usage of the instruction in D (source registers with their use
//   times, destination register with its result-ready time). It keeps a
//   registered shadow of the E, M and W stage records. From these it drives
//   the pipeline stall and the forwarding selects for the D, E and M read
//   points.
//
// Ports
//   HCU_i_Clk        clock
//   HCU_i_Reset      synchronous, active-high reset (clears all records)
//   HCU_i_RsD/RtD    source registers of the instruction in D
//   HCU_i_TuseRsD/RtD  stage at which each source is read
//                    (0=D, 1=E, 2=M, T_NEVER=not read)
//   HCU_i_TnewD      cycles until the result lands in a pipeline register
//   HCU_i_RegWAddrD  destination register of the instruction in D
//   HCU_o_Stall      freeze PC and IF/ID, insert a bubble into ID/EX
//   HCU_o_FwdRsD/RtD D read select: 0 RF, 1 ID/EX, 2 EX/MEM, 3 MEM/WB
//   HCU_o_FwdRsE/RtE E read select: 0 ID/EX reg, 2 EX/MEM, 3 MEM/WB
//   HCU_o_FwdRtM     M read select: 0 EX/MEM reg, 1 MEM/WB
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int                   T_WIDTH = 4,
  parameter logic [T_WIDTH-1:0]   T_NEVER = {T_WIDTH{1'b1}}
) (
  input  logic               HCU_i_Clk,
  input  logic               HCU_i_Reset,
  input  logic [4:0]         HCU_i_RsD,
  input  logic [4:0]         HCU_i_RtD,
  input  logic [T_WIDTH-1:0] HCU_i_TuseRsD,
  input  logic [T_WIDTH-1:0] HCU_i_TuseRtD,
  input  logic [T_WIDTH-1:0] HCU_i_TnewD,
  input  logic [4:0]         HCU_i_RegWAddrD,
  output logic               HCU_o_Stall,
  output logic [1:0]         HCU_o_FwdRsD,
  output logic [1:0]         HCU_o_FwdRtD,
  output logic [1:0]         HCU_o_FwdRsE,
  output logic [1:0]         HCU_o_FwdRtE,
  output logic               HCU_o_FwdRtM
);

  // E and M records carry consumer registers for their own read points.
  typedef struct packed {
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         waddr;
    logic [T_WIDTH-1:0] tnew;
  } rec_t;

  // W is the last stage. It is only ever a producer, so it keeps no
  // consumer fields.
  typedef struct packed {
    logic [4:0]         waddr;
    logic [T_WIDTH-1:0] tnew;
  } prod_t;

  // Result of the nearest-producer search for one D source register.
  typedef struct packed {
    logic               hit;
    logic [1:0]         sel;   // 1=E, 2=M, 3=W (the matching D select code)
    logic [T_WIDTH-1:0] tnew;
  } near_t;

  rec_t  e_q, e_d;
  rec_t  m_q, m_d;
  prod_t w_q, w_d;

  near_t near_rs, near_rt;
  logic  stall_rs, stall_rt;

  function automatic logic [T_WIDTH-1:0] sat_dec(input logic [T_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // $0 is hard-wired to zero, so a zero destination never matches.
  function automatic logic is_match(input logic [4:0] waddr, input logic [4:0] r);
    return (waddr != 5'd0) && (waddr == r);
  endfunction

  // Youngest producer wins. An older match for the same register holds a
  // stale value, so it is ignored.
  function automatic near_t nearest(input logic [4:0] r, input rec_t e,
                                    input rec_t m, input prod_t w);
    near_t n;
    n = '0;
    if (is_match(e.waddr, r)) begin
      n.hit = 1'b1; n.sel = 2'd1; n.tnew = e.tnew;
    end else if (is_match(m.waddr, r)) begin
      n.hit = 1'b1; n.sel = 2'd2; n.tnew = m.tnew;
    end else if (is_match(w.waddr, r)) begin
      n.hit = 1'b1; n.sel = 2'd3; n.tnew = w.tnew;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection and forwarding (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    HCU_o_FwdRsD = 2'd0;
    HCU_o_FwdRtD = 2'd0;
    HCU_o_FwdRsE = 2'd0;
    HCU_o_FwdRtE = 2'd0;
    HCU_o_FwdRtM = 1'b0;

    near_rs = nearest(HCU_i_RsD, e_q, m_q, w_q);
    near_rt = nearest(HCU_i_RtD, e_q, m_q, w_q);

    // A source stalls when its value is still further away than the stage
    // that needs it. T_NEVER sources are not read, so they never stall.
    stall_rs = near_rs.hit && (HCU_i_TuseRsD != T_NEVER) && (near_rs.tnew > HCU_i_TuseRsD);
    stall_rt = near_rt.hit && (HCU_i_TuseRtD != T_NEVER) && (near_rt.tnew > HCU_i_TuseRtD);
    HCU_o_Stall = stall_rs | stall_rt;

    // D forwarding only takes a value that already sits in a pipeline
    // register. The W path covers the register file's lack of write-through.
    if (near_rs.hit && near_rs.tnew == '0) HCU_o_FwdRsD = near_rs.sel;
    if (near_rt.hit && near_rt.tnew == '0) HCU_o_FwdRtD = near_rt.sel;

    // E read point: EX/MEM when M has the value ready, else MEM/WB.
    if (is_match(m_q.waddr, e_q.rs) && m_q.tnew == '0) HCU_o_FwdRsE = 2'd2;
    else if (is_match(w_q.waddr, e_q.rs))                HCU_o_FwdRsE = 2'd3;

    if (is_match(m_q.waddr, e_q.rt) && m_q.tnew == '0) HCU_o_FwdRtE = 2'd2;
    else if (is_match(w_q.waddr, e_q.rt))                HCU_o_FwdRtE = 2'd3;

    // M read point (store data): only W can still be ahead of it.
    HCU_o_FwdRtM = is_match(w_q.waddr, m_q.rt);
  end

  // ---------------------------------------------------------------------------
  // Record advance
  // ---------------------------------------------------------------------------
  always_comb begin
    w_d.waddr = m_q.waddr;
    w_d.tnew  = sat_dec(m_q.tnew);

    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);

    // On a stall, D stays in IF/ID and a bubble enters E. Nothing is lost:
    // D is re-presented next cycle.
    e_d = '0;
    if (!HCU_o_Stall) begin
      e_d.rs    = HCU_i_RsD;
      e_d.rt    = HCU_i_RtD;
      e_d.waddr = HCU_i_RegWAddrD;
      e_d.tnew  = sat_dec(HCU_i_TnewD);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // record updates from the values of the previous cycle. The reset is
  // synchronous and takes priority over a pending stall.
  always_ff @(posedge HCU_i_Clk) begin
    if (HCU_i_Reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed scoreboard bench. Each stimulus cycle pushes its hand-derived
//   expected outputs into a queue. A monitor on the falling edge pops one
//   entry per cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [3:0] NV = 4'hF;  // "never read"

  logic       clk;
  logic       rst;
  logic [4:0] rs_d, rt_d, waddr_d;
  logic [3:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;

  hazard_ctrl #(.T_WIDTH(4), .T_NEVER(4'hF)) dut (
    .HCU_i_Clk       (clk),
    .HCU_i_Reset     (rst),
    .HCU_i_RsD       (rs_d),
    .HCU_i_RtD       (rt_d),
    .HCU_i_TuseRsD   (tuse_rs_d),
    .HCU_i_TuseRtD   (tuse_rt_d),
    .HCU_i_TnewD     (tnew_d),
    .HCU_i_RegWAddrD (waddr_d),
    .HCU_o_Stall     (stall),
    .HCU_o_FwdRsD    (fwd_rs_d),
    .HCU_o_FwdRtD    (fwd_rt_d),
    .HCU_o_FwdRsE    (fwd_rs_e),
    .HCU_o_FwdRtE    (fwd_rt_e),
    .HCU_o_FwdRtM    (fwd_rt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall_only;  // selects are don't-care while stalled
    logic       stall;
    logic [1:0] rsd, rtd, rse, rte;
    logic       rtm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".stall"}, int'(stall), int'(e.stall));
      if (!e.stall_only) begin
        check({e.name, ".fwd_rs_d"}, int'(fwd_rs_d), int'(e.rsd));
        check({e.name, ".fwd_rt_d"}, int'(fwd_rt_d), int'(e.rtd));
        check({e.name, ".fwd_rs_e"}, int'(fwd_rs_e), int'(e.rse));
        check({e.name, ".fwd_rt_e"}, int'(fwd_rt_e), int'(e.rte));
        check({e.name, ".fwd_rt_m"}, int'(fwd_rt_m), int'(e.rtm));
      end
    end
  end

  // Drive one D instruction for one cycle and queue its expected outputs.
  task automatic apply(input string name, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [3:0] tur, input logic [3:0] tut,
                       input logic [3:0] tn, input logic [4:0] wa,
                       input logic e_stall, input logic [1:0] e_rsd,
                       input logic [1:0] e_rtd, input logic [1:0] e_rse,
                       input logic [1:0] e_rte, input logic e_rtm,
                       input logic only_stall);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs_d = rs; rt_d = rt; tuse_rs_d = tur; tuse_rt_d = tut;
    tnew_d = tn; waddr_d = wa;
    e.name = name; e.stall_only = only_stall; e.stall = e_stall;
    e.rsd = e_rsd; e.rtd = e_rtd; e.rse = e_rse; e.rte = e_rte; e.rtm = e_rtm;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; rs_d = '0; rt_d = '0; tuse_rs_d = NV; tuse_rt_d = NV;
    tnew_d = '0; waddr_d = '0;
    repeat (2) @(posedge clk);

    //     name         rst rs  rt  tuRs tuRt tn  wa   stall rsd rtd rse rte rtm only
    // Reset state: records cleared, D inputs irrelevant.
    apply("rst_state",  1, 3,  3,  1,  1,  2,  4,   0, 0, 0, 0, 0, 0, 0);
    // lw $3 then addu $4,$3,$3
    apply("lw3",        0, 29, 3,  1,  NV, 3,  3,   0, 0, 0, 0, 0, 0, 0);
    apply("addu_stall", 0, 3,  3,  1,  1,  2,  4,   1, 0, 0, 0, 0, 0, 1);
    apply("addu_go",    0, 3,  3,  1,  1,  2,  4,   0, 0, 0, 0, 0, 0, 0);
    apply("addu_in_e",  0, 0,  0,  NV, NV, 0,  0,   0, 0, 0, 3, 3, 0, 0);
    // addu $3 then beq $3,$3
    apply("addu3",      0, 1,  2,  1,  1,  2,  3,   0, 0, 0, 0, 0, 0, 0);
    apply("beq_stall",  0, 3,  3,  0,  0,  0,  0,   1, 0, 0, 0, 0, 0, 1);
    apply("beq_go",     0, 3,  3,  0,  0,  0,  0,   0, 2, 2, 0, 0, 0, 0);
    // jal then jr $31 (beq now in E picks up addu $3 from W)
    apply("jal",        0, 0,  0,  NV, NV, 1,  31,  0, 0, 0, 3, 3, 0, 0);
    apply("jr31",       0, 31, 0,  0,  NV, 0,  0,   0, 1, 0, 0, 0, 0, 0);
    // lw $5 then sw $5,0($6) (jr in E takes $31 from EX/MEM)
    apply("lw5",        0, 29, 5,  1,  NV, 3,  5,   0, 0, 0, 2, 0, 0, 0);
    apply("sw5",        0, 6,  5,  1,  2,  0,  0,   0, 0, 0, 0, 0, 0, 0);
    apply("sw_in_e",    0, 0,  0,  NV, NV, 0,  0,   0, 0, 0, 0, 0, 0, 0);
    apply("sw_in_m",    0, 0,  0,  NV, NV, 0,  0,   0, 0, 0, 0, 0, 1, 0);
    // ori $0 then addu $1,$0,$0: register $0 never matches
    apply("ori0",       0, 0,  0,  1,  NV, 2,  0,   0, 0, 0, 0, 0, 0, 0);
    apply("addu1_00",   0, 0,  0,  1,  1,  2,  1,   0, 0, 0, 0, 0, 0, 0);
    // $1 named with T_NEVER while its producer is pending: no stall
    apply("never_rd",   0, 1,  1,  NV, NV, 0,  0,   0, 0, 0, 0, 0, 0, 0);
    apply("never_in_e", 0, 0,  0,  NV, NV, 0,  0,   0, 0, 0, 2, 2, 0, 0);
    // Reset during a lw/addu stall (never_rd record in M reads $1 from W)
    apply("lw3_b",      0, 29, 3,  1,  NV, 3,  3,   0, 0, 0, 0, 0, 1, 0);
    apply("stall_rst",  1, 3,  3,  1,  1,  2,  4,   1, 0, 0, 0, 0, 0, 1);
    apply("after_rst",  0, 3,  3,  1,  1,  2,  4,   0, 0, 0, 0, 0, 0, 0);
    apply("after_rst2", 0, 0,  0,  NV, NV, 0,  0,   0, 0, 0, 0, 0, 0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
